// File: rtl/alu_mult_sequencer_pkg.sv
// Shared constants for the multiply sequencer and the datapath ALU.
//   ALU op codes : ALU_NOP / ALU_OR / ALU_ADD (same codes the ALU decode uses)
//   state_t      : 2-bit sequencer state encoding
package alu_mult_sequencer_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the datapath ALU for its
// additions and its "multiplier exhausted" test. Returns the low WIDTH bits.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start_i                    request, honoured only in IDLE
//   multiplicand_i/multiplier_i operands captured on accepted start
//   busy_o                     high while iterating (CHECK/ACC)
//   done_o                     one-cycle pulse when product_o becomes valid
//   product_o                  registered product, held until next DONE
//   alu_operation_o/alu_a_o/alu_b_o  request to the combinational ALU
//   alu_data_i/alu_zero_i      ALU result and zero flag
module alu_mult_sequencer
  import alu_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic [3:0]       alu_operation_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic             alu_zero_i
);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  acc, mcand, mplier;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;

  assign last_bit = (bit_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      bit_cnt   <= '0;
      product_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start_i) begin
          mcand   <= multiplicand_i;
          mplier  <= multiplier_i;
          acc     <= '0;
          bit_cnt <= '0;
        end
        // Early exit: remaining multiplier bits are all zero, acc is final.
        CHECK: if (alu_zero_i) product_o <= acc;
        ACC: begin
          acc     <= alu_data_i;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          // Final bit: the sum being written to acc is the product, so
          // capture it now so product_o is valid alongside done_o.
          if (last_bit) product_o <= alu_data_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    alu_operation_o = ALU_NOP;
    alu_a_o         = '0;
    alu_b_o         = '0;
    case (state)
      IDLE:  if (start_i) state_nxt = CHECK;
      CHECK: begin
        busy_o          = 1'b1;
        alu_operation_o = ALU_OR;
        alu_a_o         = mplier;
        state_nxt       = alu_zero_i ? DONE : ACC;
      end
      ACC: begin
        busy_o          = 1'b1;
        alu_operation_o = ALU_ADD;
        alu_a_o         = acc;
        alu_b_o         = mplier[0] ? mcand : '0;
        state_nxt       = last_bit ? DONE : CHECK;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Randomised self-checking bench for alu_mult_sequencer with a behavioural
// ALU attached to the alu_* ports.
module tb_alu_mult_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [31:0] multiplicand_i, multiplier_i;
  logic        busy_o, done_o;
  logic [31:0] product_o;
  logic [3:0]  alu_operation_o;
  logic [31:0] alu_a_o, alu_b_o, alu_data_i;
  logic        alu_zero_i;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_mult_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i),
    .busy_o(busy_o), .done_o(done_o), .product_o(product_o),
    .alu_operation_o(alu_operation_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i)
  );

  // Datapath ALU
  always_comb begin
    case (alu_operation_o)
      4'b0011: alu_data_i = alu_a_o + alu_b_o;
      4'b0001: alu_data_i = alu_a_o | alu_b_o;
      default: alu_data_i = '0;
    endcase
    alu_zero_i = (alu_data_i == '0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts a multiply from a negedge with the DUT idle, then follows it
  // cycle by cycle. Cycle c is sampled at the c-th negedge after the
  // start-sampling edge. repulse re-asserts start with other operands
  // mid-run; rst_at>0 asserts reset in cycle rst_at and checks the abort.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input bit repulse, input int rst_at);
    logic [31:0] exp_p;
    int k, exp_lat, lat, adds;
    bit busy_ok, seen;
    exp_p = a * b;
    k = -1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i;
    exp_lat = (k < 0) ? 2 : (k == 31) ? 65 : 4 + 2 * k;
    multiplicand_i = a;
    multiplier_i   = b;
    start_i        = 1'b1;
    @(posedge clk);
    seen = 0; adds = 0; busy_ok = 1; lat = 0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("rst_busy",    busy_o, 0);
        chk("rst_done",    done_o, 0);
        chk("rst_product", product_o, 0);
        chk("rst_aluop",   alu_operation_o, 0);
        reset = 1'b0;
        return;
      end
      if (alu_operation_o == 4'b0011) adds++;
      if (done_o) begin
        seen = 1; lat = c;
      end else if (!busy_o) busy_ok = 0;
      if (c == 1) begin
        start_i = 1'b0;
        multiplicand_i = $urandom;
        multiplier_i   = $urandom;
      end
      if (repulse && c == 3) begin
        start_i = 1'b1;
        multiplicand_i = $urandom;
        multiplier_i   = $urandom | 32'h1;
      end
      if (repulse && c == 4) start_i = 1'b0;
      if (rst_at > 0 && c == rst_at) reset = 1'b1;
    end
    if (rst_at > 0) begin
      chk("rst_no_done", seen, 0);
      reset = 1'b0;
      return;
    end
    chk("latency", lat, exp_lat);
    chk("product", product_o, exp_p);
    chk("busy_span", busy_ok, 1);
    chk("add_cycles", adds, k + 1);
    @(negedge clk);
    chk("idle_after_done", {done_o, busy_o}, 0);
    chk("product_hold", product_o, exp_p);
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; multiplicand_i = '0; multiplier_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_product", product_o, 0);
    chk("reset_aluop", alu_operation_o, 0);
    chk("reset_alu_ab", {alu_a_o, alu_b_o}, 0);
    reset = 1'b0;
    @(negedge clk);

    run(32'd6, 32'd7, 0, 0);
    run(32'h12345678, 32'd0, 0, 0);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run(32'd3, 32'd5, 1, 0);
    run(32'd2, 32'd2, 0, 0);           // back-to-back, start in IDLE after DONE
    run(32'd100, 32'h80000001, 0, 10); // reset aborts the run
    run(32'd2, 32'd3, 0, 0);
    run(32'h00000100, 32'd9, 0, 0);
    run(32'd9, 32'h00000100, 0, 0);

    for (int t = 0; t < 25; t++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (t % 7 == 0) rb = '0;
      run(ra, rb, (t % 5 == 1), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
